// File: rtl/axi_sram_slave_if.sv
// ---------------------------------------------------------------------------
// axi_sram_slave_if
//   AXI3-style bus bundle between a 32-bit master and the axi_sram_slave
//   memory model. Clock and reset are kept outside the bundle.
//
//   Read address : arid[3:0] araddr[31:0] arlen[7:0] arsize[2:0] arburst[1:0]
//                  arvalid / arready
//   Read data    : rid[3:0] rdata[31:0] rresp[1:0] rlast  rvalid / rready
//   Write address: awid[3:0] awaddr[31:0] awlen[3:0] awsize[2:0] awburst[1:0]
//                  awvalid / awready
//   Write data   : wid[3:0] wdata[31:0] wstrb[3:0] wlast  wvalid / wready
//   Write resp   : bid[3:0] bresp[1:0]  bvalid / bready
//
//   Modports: slave (memory side), master (initiator side).
// ---------------------------------------------------------------------------
interface axi_sram_slave_if;
    logic [3:0]  arid;
    logic [31:0] araddr;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic        arvalid;
    logic        arready;

    logic [3:0]  rid;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rlast;
    logic        rvalid;
    logic        rready;

    logic [3:0]  awid;
    logic [31:0] awaddr;
    logic [3:0]  awlen;
    logic [2:0]  awsize;
    logic [1:0]  awburst;
    logic        awvalid;
    logic        awready;

    logic [3:0]  wid;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wlast;
    logic        wvalid;
    logic        wready;

    logic [3:0]  bid;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;

    modport slave (
        input  arid, araddr, arlen, arsize, arburst, arvalid,
        output arready,
        output rid, rdata, rresp, rlast, rvalid,
        input  rready,
        input  awid, awaddr, awlen, awsize, awburst, awvalid,
        output awready,
        input  wid, wdata, wstrb, wlast, wvalid,
        output wready,
        output bid, bresp, bvalid,
        input  bready
    );

    modport master (
        output arid, araddr, arlen, arsize, arburst, arvalid,
        input  arready,
        input  rid, rdata, rresp, rlast, rvalid,
        output rready,
        output awid, awaddr, awlen, awsize, awburst, awvalid,
        input  awready,
        output wid, wdata, wstrb, wlast, wvalid,
        input  wready,
        input  bid, bresp, bvalid,
        output bready
    );
endinterface

// File: rtl/axi_sram_slave.sv
// ---------------------------------------------------------------------------
// axi_sram_slave
//   AXI responder backed by a word-addressed SRAM of 2**MEM_AW 32-bit words.
//   Independent read and write engines, one outstanding burst each,
//   FIXED / INCR bursts (WRAP stepped as INCR), byte-strobed writes.
//
//   Parameters: MEM_AW    log2 of depth in words
//               BASE_ADDR byte address of word 0
//   Ports     : aclk      clock, rising edge
//               aresetn   asynchronous active-low reset
//               bus       axi_sram_slave_if.slave (all AXI channels)
//
//   Optional feature macro AXI_SRAM_SLAVE_DECERR_EN:
//     defined   -> beats outside [BASE_ADDR, BASE_ADDR + 4<<MEM_AW) return
//                  DECERR with zero read data; such write beats are dropped.
//     undefined -> addresses wrap modulo the memory size, always decoded.
//   Memory contents survive reset.
// ---------------------------------------------------------------------------
module axi_sram_slave #(
    parameter int unsigned MEM_AW    = 10,
    parameter logic [31:0] BASE_ADDR = 32'h0
) (
    input logic             aclk,
    input logic             aresetn,
    axi_sram_slave_if.slave bus
);
    localparam int unsigned DEPTH       = 1 << MEM_AW;
    localparam logic [1:0]  RESP_OKAY   = 2'b00;
    localparam logic [1:0]  RESP_SLVERR = 2'b10;
    localparam logic [1:0]  RESP_DECERR = 2'b11;
    localparam logic [1:0]  BURST_FIXED = 2'b00;

    typedef enum logic       {R_IDLE, R_BURST} r_state_e;
    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_e;

    function automatic logic [MEM_AW-1:0] word_idx(input logic [31:0] addr);
        return MEM_AW'((addr - BASE_ADDR) >> 2);
    endfunction

    // FIXED keeps the address; INCR and WRAP both advance by the beat size.
    function automatic logic [31:0] step_addr(input logic [31:0] addr,
                                              input logic [2:0]  size,
                                              input logic [1:0]  burst);
        return (burst == BURST_FIXED) ? addr : addr + (32'd1 << size);
    endfunction

`ifdef AXI_SRAM_SLAVE_DECERR_EN
    function automatic logic out_of_range(input logic [31:0] addr);
        logic [31:0] offset;
        offset = addr - BASE_ADDR;
        return (addr < BASE_ADDR) || (offset >= (32'd4 << MEM_AW));
    endfunction
`endif

    logic [31:0] mem [DEPTH];

    // -----------------------------------------------------------------------
    // Read engine
    // -----------------------------------------------------------------------
    r_state_e    r_state_q, r_state_d;
    logic [3:0]  rid_q, rid_d;
    logic [31:0] raddr_q, raddr_d;          // address of the next beat to fetch
    logic [7:0]  rlen_q, rlen_d;
    logic [7:0]  rcnt_q, rcnt_d;            // index of the beat held in rdata_q
    logic [2:0]  rsize_q, rsize_d;
    logic [1:0]  rburst_q, rburst_d;
    logic [31:0] rdata_q, rdata_d;
    logic [1:0]  rresp_q, rresp_d;
    logic        rlast_q, rlast_d;

    logic        ar_hs, r_hs, r_fetch;
    logic [31:0] r_fetch_addr;
    logic [2:0]  r_fetch_size;
    logic [1:0]  r_fetch_burst;

    assign ar_hs = (r_state_q == R_IDLE) && bus.arvalid;
    assign r_hs  = (r_state_q == R_BURST) && bus.rready;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of process evaluation order.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) r_state_q <= R_IDLE;
        else          r_state_q <= r_state_d;
    end

    always_comb begin
        r_state_d = r_state_q;
        case (r_state_q)
            R_IDLE:  if (ar_hs)            r_state_d = R_BURST;
            R_BURST: if (r_hs && rlast_q)  r_state_d = R_IDLE;
            default:                       r_state_d = R_IDLE;
        endcase
    end

    always_comb begin
        bus.arready = (r_state_q == R_IDLE);
        bus.rvalid  = (r_state_q == R_BURST);
        bus.rid     = rid_q;
        bus.rdata   = rdata_q;
        bus.rresp   = rresp_q;
        bus.rlast   = rlast_q;
    end

    // The next word is fetched either on AR accept or on a non-final beat
    // handshake, so consecutive beats leave without a bubble.
    // NOTE: every combinational output gets a default first; a path that
    // leaves a variable unassigned would otherwise infer a latch.
    always_comb begin
        rid_d         = rid_q;
        raddr_d       = raddr_q;
        rlen_d        = rlen_q;
        rcnt_d        = rcnt_q;
        rsize_d       = rsize_q;
        rburst_d      = rburst_q;
        rdata_d       = rdata_q;
        rresp_d       = rresp_q;
        rlast_d       = rlast_q;
        r_fetch       = 1'b0;
        r_fetch_addr  = raddr_q;
        r_fetch_size  = rsize_q;
        r_fetch_burst = rburst_q;

        if (ar_hs) begin
            rid_d         = bus.arid;
            rlen_d        = bus.arlen;
            rsize_d       = bus.arsize;
            rburst_d      = bus.arburst;
            rcnt_d        = 8'd0;
            rlast_d       = (bus.arlen == 8'd0);
            r_fetch       = 1'b1;
            r_fetch_addr  = bus.araddr;
            r_fetch_size  = bus.arsize;
            r_fetch_burst = bus.arburst;
        end else if (r_hs && !rlast_q) begin
            rcnt_d  = rcnt_q + 8'd1;
            rlast_d = ((rcnt_q + 8'd1) == rlen_q);
            r_fetch = 1'b1;
        end

        if (r_fetch) begin
            raddr_d = step_addr(r_fetch_addr, r_fetch_size, r_fetch_burst);
`ifdef AXI_SRAM_SLAVE_DECERR_EN
            if (out_of_range(r_fetch_addr)) begin
                rdata_d = 32'd0;
                rresp_d = RESP_DECERR;
            end else begin
                rdata_d = mem[word_idx(r_fetch_addr)];
                rresp_d = RESP_OKAY;
            end
`else
            rdata_d = mem[word_idx(r_fetch_addr)];
            rresp_d = RESP_OKAY;
`endif
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            rid_q    <= '0;
            raddr_q  <= '0;
            rlen_q   <= '0;
            rcnt_q   <= '0;
            rsize_q  <= '0;
            rburst_q <= '0;
            rdata_q  <= '0;
            rresp_q  <= RESP_OKAY;
            rlast_q  <= 1'b0;
        end else begin
            rid_q    <= rid_d;
            raddr_q  <= raddr_d;
            rlen_q   <= rlen_d;
            rcnt_q   <= rcnt_d;
            rsize_q  <= rsize_d;
            rburst_q <= rburst_d;
            rdata_q  <= rdata_d;
            rresp_q  <= rresp_d;
            rlast_q  <= rlast_d;
        end
    end

    // -----------------------------------------------------------------------
    // Write engine
    // -----------------------------------------------------------------------
    w_state_e    w_state_q, w_state_d;
    logic [3:0]  bid_q, bid_d;
    logic [31:0] waddr_q, waddr_d;
    logic [3:0]  wlen_q, wlen_d;
    logic [3:0]  wcnt_q, wcnt_d;
    logic [2:0]  wsize_q, wsize_d;
    logic [1:0]  wburst_q, wburst_d;
    logic        werr_q, werr_d;            // sticky wlast/beat-count mismatch
    logic        wdec_q, wdec_d;            // sticky out-of-range beat

    logic        aw_hs, w_hs, w_beat_last, w_oor, mem_we;

    assign aw_hs       = (w_state_q == W_IDLE) && bus.awvalid;
    assign w_hs        = (w_state_q == W_DATA) && bus.wvalid;
    assign w_beat_last = (wcnt_q == wlen_q);
`ifdef AXI_SRAM_SLAVE_DECERR_EN
    assign w_oor       = out_of_range(waddr_q);
`else
    assign w_oor       = 1'b0;
`endif
    assign mem_we      = w_hs && !w_oor;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) w_state_q <= W_IDLE;
        else          w_state_q <= w_state_d;
    end

    // The beat count alone ends the burst; wlast only feeds the error flag.
    always_comb begin
        w_state_d = w_state_q;
        case (w_state_q)
            W_IDLE:  if (aw_hs)               w_state_d = W_DATA;
            W_DATA:  if (w_hs && w_beat_last) w_state_d = W_RESP;
            W_RESP:  if (bus.bready)          w_state_d = W_IDLE;
            default:                          w_state_d = W_IDLE;
        endcase
    end

    always_comb begin
        bus.awready = (w_state_q == W_IDLE);
        bus.wready  = (w_state_q == W_DATA);
        bus.bvalid  = (w_state_q == W_RESP);
        bus.bid     = bid_q;
        bus.bresp   = RESP_OKAY;
        if (w_state_q == W_RESP) begin
            if (wdec_q)      bus.bresp = RESP_DECERR;
            else if (werr_q) bus.bresp = RESP_SLVERR;
        end
    end

    always_comb begin
        bid_d    = bid_q;
        waddr_d  = waddr_q;
        wlen_d   = wlen_q;
        wcnt_d   = wcnt_q;
        wsize_d  = wsize_q;
        wburst_d = wburst_q;
        werr_d   = werr_q;
        wdec_d   = wdec_q;
        if (aw_hs) begin
            bid_d    = bus.awid;
            waddr_d  = bus.awaddr;
            wlen_d   = bus.awlen;
            wsize_d  = bus.awsize;
            wburst_d = bus.awburst;
            wcnt_d   = 4'd0;
            werr_d   = 1'b0;
            wdec_d   = 1'b0;
        end else if (w_hs) begin
            wcnt_d  = wcnt_q + 4'd1;
            waddr_d = step_addr(waddr_q, wsize_q, wburst_q);
            werr_d  = werr_q | (bus.wlast != w_beat_last);
            wdec_d  = wdec_q | w_oor;
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            bid_q    <= '0;
            waddr_q  <= '0;
            wlen_q   <= '0;
            wcnt_q   <= '0;
            wsize_q  <= '0;
            wburst_q <= '0;
            werr_q   <= 1'b0;
            wdec_q   <= 1'b0;
        end else begin
            bid_q    <= bid_d;
            waddr_q  <= waddr_d;
            wlen_q   <= wlen_d;
            wcnt_q   <= wcnt_d;
            wsize_q  <= wsize_d;
            wburst_q <= wburst_d;
            werr_q   <= werr_d;
            wdec_q   <= wdec_d;
        end
    end

    // NOTE: the array has no reset branch: contents must survive aresetn, and
    // a reset on a memory prevents mapping it onto RAM blocks.
    // A read fetch of the same word on this edge sees the pre-write value.
    always_ff @(posedge aclk) begin
        if (mem_we) begin
            for (int i = 0; i < 4; i++) begin
                if (bus.wstrb[i]) mem[word_idx(waddr_q)][8*i +: 8] <= bus.wdata[8*i +: 8];
            end
        end
    end

    // wid carries no meaning for this slave.
    logic unused_wid;
    assign unused_wid = ^bus.wid;

endmodule

// File: tb/tb_axi_sram_slave.sv
// ---------------------------------------------------------------------------
// tb_axi_sram_slave
//   Scoreboard bench for axi_sram_slave (default parameters: 1024 words,
//   BASE_ADDR 0). Expected R beats and B responses are computed from a
//   reference memory when a transaction is issued and compared as the DUT
//   hands them over. Inputs change and outputs are sampled on the falling
//   clock edge; the DUT acts on the rising edge.
// ---------------------------------------------------------------------------
module tb_axi_sram_slave;
    logic aclk    = 1'b0;
    logic aresetn = 1'b0;
    always #5 aclk = ~aclk;

    axi_sram_slave_if bus ();

    axi_sram_slave dut (
        .aclk    (aclk),
        .aresetn (aresetn),
        .bus     (bus)
    );

    typedef struct packed {
        logic [3:0]  id;
        logic [31:0] data;
        logic [1:0]  resp;
        logic        last;
    } rbeat_t;

    typedef struct packed {
        logic [3:0] id;
        logic [1:0] resp;
    } bexp_t;

    rbeat_t      r_q[$];
    bexp_t       b_q[$];
    logic [31:0] ref_mem [1024];
    int          n_vec = 0;
    int          n_err = 0;

    function automatic logic model_oor(input logic [31:0] a);
`ifdef AXI_SRAM_SLAVE_DECERR_EN
        return a >= 32'h0000_1000;
`else
        return 1'b0;
`endif
    endfunction

    function automatic int model_idx(input logic [31:0] a);
        return int'(a[11:2]);
    endfunction

    function automatic logic [31:0] model_step(input logic [31:0] a, input logic [2:0] size,
                                               input logic [1:0] burst);
        if (burst == 2'b00) return a;
        return a + (32'd1 << size);
    endfunction

    task automatic tick();
        @(posedge aclk);
        @(negedge aclk);
    endtask

    // -----------------------------------------------------------------------
    task automatic do_write(input logic [3:0] id, input logic [31:0] addr, input logic [3:0] len,
                            input logic [2:0] size, input logic [1:0] burst,
                            input logic [31:0] d_base, input logic [31:0] d_step,
                            input logic [3:0] strb, input int last_beat, input int bready_delay);
        logic [31:0] a, d;
        logic        err, dec;
        bexp_t       e;
        int          cyc;

        a = addr; err = 1'b0; dec = 1'b0;
        for (int b = 0; b <= int'(len); b++) begin
            d = d_base + d_step * b;
            if ((b == last_beat) != (b == int'(len))) err = 1'b1;
            if (model_oor(a)) dec = 1'b1;
            else for (int i = 0; i < 4; i++)
                if (strb[i]) ref_mem[model_idx(a)][8*i +: 8] = d[8*i +: 8];
            a = model_step(a, size, burst);
        end
        e.id = id;
        e.resp = dec ? 2'b11 : (err ? 2'b10 : 2'b00);
        b_q.push_back(e);

        // AW together with the first W beat: W must not be taken before AW.
        @(negedge aclk);
        bus.awid = id; bus.awaddr = addr; bus.awlen = len; bus.awsize = size;
        bus.awburst = burst; bus.awvalid = 1'b1;
        bus.wdata = d_base; bus.wstrb = strb; bus.wlast = (last_beat == 0); bus.wvalid = 1'b1;
        n_vec++;
        if (bus.wready !== 1'b0) begin
            n_err++; $display("FAIL wready_before_aw: got %b expected 0", bus.wready);
        end
        cyc = 0;
        while (bus.awready !== 1'b1 && cyc < 50) begin tick(); cyc++; end
        n_vec++;
        if (bus.awready !== 1'b1) begin
            n_err++; $display("FAIL aw_timeout: awready got %b expected 1", bus.awready);
        end
        tick();
        bus.awvalid = 1'b0;

        for (int b = 0; b <= int'(len); b++) begin
            bus.wdata = d_base + d_step * b;
            bus.wlast = (b == last_beat);
            bus.wvalid = 1'b1;
            cyc = 0;
            while (bus.wready !== 1'b1 && cyc < 50) begin tick(); cyc++; end
            if (bus.wready !== 1'b1) begin
                n_vec++; n_err++; $display("FAIL w_timeout: beat %0d wready got %b expected 1", b, bus.wready);
            end
            tick();
        end
        bus.wvalid = 1'b0; bus.wlast = 1'b0;

        for (int k = 0; k < bready_delay; k++) begin
            n_vec++;
            if (bus.bvalid !== 1'b1 || bus.awready !== 1'b0) begin
                n_err++; $display("FAIL b_hold: cycle %0d bvalid/awready got %b/%b expected 1/0",
                                  k, bus.bvalid, bus.awready);
            end
            tick();
        end

        bus.bready = 1'b1;
        cyc = 0;
        while (bus.bvalid !== 1'b1 && cyc < 50) begin tick(); cyc++; end
        e = b_q.pop_front();
        n_vec++;
        if (bus.bvalid !== 1'b1) begin
            n_err++; $display("FAIL b_timeout: bvalid got %b expected 1", bus.bvalid);
        end else if (bus.bresp !== e.resp || bus.bid !== e.id) begin
            n_err++; $display("FAIL bresp: got id %h resp %b expected id %h resp %b",
                              bus.bid, bus.bresp, e.id, e.resp);
        end
        tick();
        bus.bready = 1'b0;
        n_vec++;
        if (bus.bvalid !== 1'b0 || bus.awready !== 1'b1) begin
            n_err++; $display("FAIL b_done: bvalid/awready got %b/%b expected 0/1", bus.bvalid, bus.awready);
        end
    endtask

    // -----------------------------------------------------------------------
    task automatic do_read(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                           input logic [2:0] size, input logic [1:0] burst, input logic toggle);
        logic [31:0] a, held_data;
        logic        held, held_last;
        rbeat_t      e;
        int          cyc, beats;

        a = addr;
        for (int b = 0; b <= int'(len); b++) begin
            e.id = id;
            e.last = (b == int'(len));
            if (model_oor(a)) begin e.data = 32'd0; e.resp = 2'b11; end
            else              begin e.data = ref_mem[model_idx(a)]; e.resp = 2'b00; end
            r_q.push_back(e);
            a = model_step(a, size, burst);
        end

        @(negedge aclk);
        bus.arid = id; bus.araddr = addr; bus.arlen = len; bus.arsize = size;
        bus.arburst = burst; bus.arvalid = 1'b1;
        cyc = 0;
        while (bus.arready !== 1'b1 && cyc < 50) begin tick(); cyc++; end
        n_vec++;
        if (bus.arready !== 1'b1) begin
            n_err++; $display("FAIL ar_timeout: arready got %b expected 1", bus.arready);
        end
        tick();
        bus.arvalid = 1'b0;
        n_vec++;
        if (bus.rvalid !== 1'b1 || bus.arready !== 1'b0) begin
            n_err++; $display("FAIL r_first_latency: rvalid/arready got %b/%b expected 1/0",
                              bus.rvalid, bus.arready);
        end

        beats = 0; cyc = 0; held = 1'b0; held_data = '0; held_last = 1'b0;
        while (beats <= int'(len) && cyc < 400) begin
            bus.rready = toggle ? ((cyc % 2) == 0) : 1'b1;
            if (bus.rvalid === 1'b1) begin
                if (held) begin
                    n_vec++;
                    if (bus.rdata !== held_data || bus.rlast !== held_last) begin
                        n_err++; $display("FAIL r_stable: got %h/%b expected %h/%b",
                                          bus.rdata, bus.rlast, held_data, held_last);
                    end
                end
                if (bus.rready) begin
                    e = r_q.pop_front();
                    n_vec++;
                    if (bus.rdata !== e.data || bus.rresp !== e.resp ||
                        bus.rlast !== e.last || bus.rid !== e.id) begin
                        n_err++; $display("FAIL r_beat %0d: got id %h data %h resp %b last %b expected id %h data %h resp %b last %b",
                                          beats, bus.rid, bus.rdata, bus.rresp, bus.rlast,
                                          e.id, e.data, e.resp, e.last);
                    end
                    beats++;
                    held = 1'b0;
                end else begin
                    held = 1'b1; held_data = bus.rdata; held_last = bus.rlast;
                end
            end
            tick();
            cyc++;
        end
        bus.rready = 1'b0;
        if (beats <= int'(len)) begin
            n_vec++; n_err++;
            $display("FAIL r_timeout: got %0d beats expected %0d", beats, int'(len) + 1);
            r_q.delete();
        end
        n_vec++;
        if (bus.rvalid !== 1'b0 || bus.arready !== 1'b1) begin
            n_err++; $display("FAIL r_done: rvalid/arready got %b/%b expected 0/1", bus.rvalid, bus.arready);
        end
    endtask

    // -----------------------------------------------------------------------
    task automatic test_reset();
        repeat (2) @(negedge aclk);
        n_vec++;
        if (bus.arready !== 1'b1 || bus.awready !== 1'b1 || bus.rvalid !== 1'b0 || bus.rlast !== 1'b0 ||
            bus.wready !== 1'b0 || bus.bvalid !== 1'b0) begin
            n_err++; $display("FAIL reset_ctrl: ar/aw/rv/rl/wr/bv got %b%b%b%b%b%b expected 110000",
                              bus.arready, bus.awready, bus.rvalid, bus.rlast, bus.wready, bus.bvalid);
        end
        n_vec++;
        if (bus.rid !== 4'h0 || bus.bid !== 4'h0 || bus.rdata !== 32'h0 ||
            bus.rresp !== 2'b00 || bus.bresp !== 2'b00) begin
            n_err++; $display("FAIL reset_data: rid %h bid %h rdata %h rresp %b bresp %b expected all zero",
                              bus.rid, bus.bid, bus.rdata, bus.rresp, bus.bresp);
        end
        aresetn = 1'b1;
        @(negedge aclk);
    endtask

    task automatic test_incr();
        do_write(4'h1, 32'h40, 4'd3, 3'd2, 2'b01, 32'h11, 32'h11, 4'hF, 3, 0);
        do_read(4'h5, 32'h40, 8'd3, 3'd2, 2'b01, 1'b0);
    endtask

    task automatic test_strobe();
        do_write(4'h2, 32'h100, 4'd0, 3'd2, 2'b01, 32'hAABBCCDD, 32'h0, 4'hF, 0, 0);
        do_write(4'h2, 32'h100, 4'd0, 3'd2, 2'b01, 32'h12345678, 32'h0, 4'b0101, 0, 0);
        do_read(4'h7, 32'h100, 8'd0, 3'd2, 2'b01, 1'b0);
        n_vec++;
        if (ref_mem[64] !== 32'hAA34CC78) begin
            n_err++; $display("FAIL strobe_model: got %h expected AA34CC78", ref_mem[64]);
        end
    endtask

    task automatic test_backpressure();
        do_write(4'h3, 32'h200, 4'd7, 3'd2, 2'b01, 32'h1000_0000, 32'h0101_0101, 4'hF, 7, 5);
        do_read(4'h8, 32'h200, 8'd7, 3'd2, 2'b01, 1'b1);
    endtask

    task automatic test_protocol_error();
        do_write(4'h4, 32'h300, 4'd1, 3'd2, 2'b01, 32'hDEAD_0000, 32'h1, 4'hF, 0, 0);
        do_read(4'h9, 32'h300, 8'd1, 3'd2, 2'b01, 1'b0);
    endtask

    task automatic test_fixed_narrow();
        do_write(4'h5, 32'h380, 4'd2, 3'd2, 2'b00, 32'h50, 32'h1, 4'hF, 2, 0);
        do_read(4'hA, 32'h380, 8'd2, 3'd2, 2'b00, 1'b0);
        // byte-sized INCR beats: four beats per word, fifth crosses into 0x44
        do_read(4'hB, 32'h40, 8'd4, 3'd0, 2'b01, 1'b0);
    endtask

    task automatic test_out_of_range();
        do_write(4'h6, 32'h0, 4'd1, 3'd2, 2'b01, 32'hCAFE_0000, 32'h1, 4'hF, 1, 0);
        do_read(4'hC, 32'h1000, 8'd0, 3'd2, 2'b01, 1'b0);
        do_write(4'h6, 32'h1004, 4'd0, 3'd2, 2'b01, 32'hBEEF_BEEF, 32'h0, 4'hF, 0, 0);
        do_read(4'hD, 32'h4, 8'd0, 3'd2, 2'b01, 1'b0);
    endtask

    task automatic test_back_to_back();
        fork
            do_write(4'h7, 32'h500, 4'd3, 3'd2, 2'b01, 32'h5500_0000, 32'h3, 4'hF, 3, 0);
            do_read(4'hE, 32'h40, 8'd3, 3'd2, 2'b01, 1'b0);
        join
        do_read(4'hF, 32'h500, 8'd3, 3'd2, 2'b01, 1'b0);
        do_read(4'h1, 32'h200, 8'd1, 3'd2, 2'b01, 1'b0);
    endtask

    task automatic test_reset_mid_burst();
        int cyc;
        @(negedge aclk);
        bus.arid = 4'h6; bus.araddr = 32'h200; bus.arlen = 8'd7; bus.arsize = 3'd2;
        bus.arburst = 2'b01; bus.arvalid = 1'b1; bus.rready = 1'b0;
        cyc = 0;
        while (bus.arready !== 1'b1 && cyc < 50) begin tick(); cyc++; end
        tick();
        bus.arvalid = 1'b0;
        bus.rready = 1'b1;
        tick();
        tick();
        bus.rready = 1'b0;
        n_vec++;
        if (bus.rvalid !== 1'b1) begin
            n_err++; $display("FAIL reset_pre_burst: rvalid got %b expected 1", bus.rvalid);
        end
        aresetn = 1'b0;
        #1;
        n_vec++;
        if (bus.rvalid !== 1'b0 || bus.arready !== 1'b1 || bus.awready !== 1'b1 ||
            bus.rlast !== 1'b0 || bus.wready !== 1'b0 || bus.bvalid !== 1'b0) begin
            n_err++; $display("FAIL reset_async: rv/ar/aw/rl/wr/bv got %b%b%b%b%b%b expected 011000",
                              bus.rvalid, bus.arready, bus.awready, bus.rlast, bus.wready, bus.bvalid);
        end
        repeat (2) @(negedge aclk);
        aresetn = 1'b1;
        bus.rready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            n_vec++;
            if (bus.rvalid !== 1'b0) begin
                n_err++; $display("FAIL reset_no_partial: cycle %0d rvalid got %b expected 0", k, bus.rvalid);
            end
            tick();
        end
        bus.rready = 1'b0;
        do_read(4'h2, 32'h200, 8'd7, 3'd2, 2'b01, 1'b0);
    endtask

    // -----------------------------------------------------------------------
    initial begin
        bus.arid = '0; bus.araddr = '0; bus.arlen = '0; bus.arsize = '0; bus.arburst = '0;
        bus.arvalid = 1'b0; bus.rready = 1'b0;
        bus.awid = '0; bus.awaddr = '0; bus.awlen = '0; bus.awsize = '0; bus.awburst = '0;
        bus.awvalid = 1'b0;
        bus.wid = '0; bus.wdata = '0; bus.wstrb = '0; bus.wlast = 1'b0; bus.wvalid = 1'b0;
        bus.bready = 1'b0;

        test_reset();
        test_incr();
        test_strobe();
        test_backpressure();
        test_protocol_error();
        test_fixed_narrow();
        test_out_of_range();
        test_back_to_back();
        test_reset_mid_burst();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end
endmodule
